// File: rtl/gray_sobel_pkg.sv
// Shared types and constants for the gray/sobel frame sequencer.
// Mode encodings mirror the datapath select_i field.
package gray_sobel_pkg;

    localparam int MAX_PIXEL_BITS = 24;

    typedef logic [1:0] sel_t;

    localparam sel_t MODE_BYPASS = 2'b00;
    localparam sel_t MODE_GRAY   = 2'b01;
    localparam sel_t MODE_SOBEL  = 2'b10;
    localparam sel_t MODE_BOTH   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/gray_sobel_out_fifo.sv
// First-word-fall-through result FIFO for SPI readback.
// Push and pop may coincide when full; the head reads 0 while empty.
module gray_sobel_out_fifo #(
    parameter int PX_W       = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic [PX_W-1:0]  wdata,
    input  logic             pop,
    output logic [PX_W-1:0]  rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PX_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = cnt_q == CNT_W'(FIFO_DEPTH);
    assign empty   = cnt_q == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt_q;
    assign rdata   = empty ? '0 : mem[rd_q];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/gray_sobel_frame_sequencer.sv
// Frame controller between spi_control and top_gray_sobel: issues pixels,
// pins the datapath mode per frame and buffers results with credit flow.
module gray_sobel_frame_sequencer
    import gray_sobel_pkg::*;
#(
    parameter int PX_W        = MAX_PIXEL_BITS,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk_i,
    input  logic            nreset_i,
    input  logic [1:0]      cfg_select_i,
    input  logic            frame_start_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [PX_W-1:0] in_pixel_i,
    output logic [1:0]      dp_select_o,
    output logic            dp_start_sobel_o,
    output logic            dp_px_rdy_o,
    output logic [PX_W-1:0] dp_pixel_o,
    input  logic            dp_px_rdy_i,
    input  logic [PX_W-1:0] dp_pixel_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PX_W-1:0] out_pixel_o,
    output logic            busy_o,
    output logic            frame_done_o,
    output logic            overflow_o,
    output logic            timeout_o
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int IDW   = $clog2(TIMEOUT_CYC + 1);
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    sel_t             mode_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [CW-1:0]    issued_q;
    logic [CW-1:0]    received_q;
    logic [IDW-1:0]   idle_q;
    logic             overflow_q;
    logic             timeout_q;
    logic             px_rdy_q;
    logic [PX_W-1:0]  pixel_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [FCW-1:0]   fifo_count;
    logic [CW:0]      credit_used;
    logic             start;
    logic             issue;
    logic             last_col;
    logic             last_row;
    logic             last_issue;
    logic             timeout_hit;
    logic             drop;

    // Results in flight plus results parked in the FIFO may never exceed its depth.
    assign credit_used = {1'b0, issued_q - received_q} + (CW+1)'(fifo_count);
    assign start       = (state_q == IDLE) && frame_start_i;
    assign issue       = in_valid_i && in_ready_o;
    assign last_col    = col_q == COL_W'(IMG_W - 1);
    assign last_row    = row_q == ROW_W'(IMG_H - 1);
    assign last_issue  = issue && last_col && last_row;
    assign timeout_hit = (state_q == DRAIN) && !dp_px_rdy_i
                         && (idle_q == IDW'(TIMEOUT_CYC - 1));
    assign fifo_pop    = out_ready_i && !fifo_empty;
    assign drop        = dp_px_rdy_i && fifo_full && !fifo_pop;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start_i) state_d = LOAD;
            LOAD:    if (last_issue) state_d = DRAIN;
            DRAIN:   if (received_q >= CW'(TOTAL) || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o           = state_q != IDLE;
        frame_done_o     = state_q == DONE;
        dp_select_o      = MODE_BYPASS;
        dp_start_sobel_o = 1'b0;
        in_ready_o       = 1'b0;
        if (state_q == LOAD || state_q == DRAIN) begin
            dp_select_o      = mode_q;
            dp_start_sobel_o = mode_q == MODE_SOBEL;
        end
        if (state_q == LOAD) in_ready_o = credit_used < (CW+1)'(FIFO_DEPTH);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            mode_q     <= MODE_BYPASS;
            col_q      <= '0;
            row_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            idle_q     <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            px_rdy_q   <= 1'b0;
            pixel_q    <= '0;
        end else begin
            px_rdy_q <= issue;
            if (issue) pixel_q <= in_pixel_i;
            if (start) begin
                mode_q     <= cfg_select_i;
                col_q      <= '0;
                row_q      <= '0;
                issued_q   <= '0;
                received_q <= '0;
                idle_q     <= '0;
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + 1'b1;
                    col_q    <= last_col ? '0 : col_q + 1'b1;
                    if (last_col) row_q <= last_row ? '0 : row_q + 1'b1;
                end
                if (dp_px_rdy_i) received_q <= received_q + 1'b1;
                if (state_q == DRAIN && !dp_px_rdy_i) idle_q <= idle_q + 1'b1;
                else                                  idle_q <= '0;
                if (drop)        overflow_q <= 1'b1;
                if (timeout_hit) timeout_q  <= 1'b1;
            end
        end
    end

    gray_sobel_out_fifo #(
        .PX_W       (PX_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_i),
        .nreset (nreset_i),
        .push   (dp_px_rdy_i),
        .wdata  (dp_pixel_i),
        .pop    (fifo_pop),
        .rdata  (out_pixel_o),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign out_valid_o = !fifo_empty;
    assign dp_px_rdy_o = px_rdy_q;
    assign dp_pixel_o  = pixel_q;
    assign overflow_o  = overflow_q;
    assign timeout_o   = timeout_q;

endmodule
